// File: rtl/result_bcd_conv_pkg.sv
// Shared types and defaults for the multiplier-result binary-to-BCD converter.
package bcd_conv_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BCD_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/result_bcd_conv_if.sv
// Capture/result bundle between the multiplier side (master) and the converter (slave).
interface result_bcd_conv_if
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
);
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic [4*DIGITS-1:0]   bcd;
  logic                  bcd_valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    output done, result,
    input  bcd, bcd_valid, busy, overrun
  );

  modport slave (
    input  done, result,
    output bcd, bcd_valid, busy, overrun
  );
endinterface

// File: rtl/result_bcd_conv_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, purely combinational.
// No latency, no flow control.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end
endmodule

// File: rtl/result_bcd_conv.sv
// Captures the product on each rising edge of done and converts it to packed BCD by shift-and-add-3.
// WIDTH cycles capture-to-valid; no backpressure, edges arriving mid-conversion are dropped and flagged.
module result_bcd_conv
  import bcd_conv_pkg::*;
#(
  parameter int WIDTH  = BCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input logic              clk,
  input logic              rst_n,
  result_bcd_conv_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_t          state;
  state_t          state_nxt;
  logic            done_q;
  logic            rise;
  logic            capture;
  logic            shift_en;
  logic            finish;
  logic            drop;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]   bcd_sr;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shifted;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcd_q;
  logic            bcd_valid_q;
  logic            busy_q;
  logic            overrun_q;

  assign rise = bus.done & ~done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_sr[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Adjusted digits shift up by one, pulling in the next binary MSB.
  assign bcd_shifted = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          capture   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        drop     = rise;
        if (cnt == CW'(WIDTH - 1)) begin
          finish    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
      cnt         <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q      <= bus.done;
      bcd_valid_q <= finish;
      if (capture) begin
        bin_sr <= bus.result;
        bcd_sr <= '0;
        cnt    <= '0;
        busy_q <= 1'b1;
      end else if (shift_en) begin
        bcd_sr <= bcd_shifted;
        bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
        cnt    <= cnt + 1'b1;
      end
      if (finish) begin
        bcd_q  <= bcd_shifted;
        busy_q <= 1'b0;
      end
      if (drop) overrun_q <= 1'b1;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Scoreboard bench for result_bcd_conv: decimal reference model, latency, overrun and reset scenarios.
module tb_result_bcd_conv;
  import bcd_conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  logic [19:0] exp_q[$];

  result_bcd_conv_if #(.WIDTH(16), .DIGITS(5)) bus ();

  result_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n === 1'b1 && bus.bcd_valid === 1'b1) begin
      valid_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: bcd=%h, no conversion outstanding", bus.bcd);
      end else begin
        e = exp_q.pop_front();
        if (bus.bcd !== e) begin
          miscompares++;
          $display("FAIL scoreboard: bcd=%h expected %h", bus.bcd, e);
        end
      end
    end
  end

  task automatic pulse(input logic [15:0] v, input bit expect_out);
    @(negedge clk);
    bus.result = v;
    bus.done   = 1'b1;
    if (expect_out) exp_q.push_back(to_bcd(int'(v)));
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.done = 1'b0;
    bus.result = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h0) begin miscompares++; $display("FAIL reset_bcd: got %h want 00000", bus.bcd); end
    vectors++;
    if (bus.bcd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.bcd_valid); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++;
    if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency;
    pulse(16'd12, 1'b1);
    vectors++;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_capture: got %b want 1", bus.busy); end
    repeat (15) @(negedge clk);
    vectors++;
    if (bus.bcd_valid !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL early_valid: valid=%b busy=%b want valid 0 busy 1", bus.bcd_valid, bus.busy);
    end
    @(negedge clk);
    vectors++;
    if (bus.bcd_valid !== 1'b1 || bus.busy !== 1'b0 || bus.bcd !== 20'h00012) begin
      miscompares++;
      $display("FAIL done_at_e16: valid=%b busy=%b bcd=%h want 1 0 00012", bus.bcd_valid, bus.busy, bus.bcd);
    end
    @(negedge clk);
    vectors++;
    if (bus.bcd_valid !== 1'b0) begin miscompares++; $display("FAIL valid_width: got %b at E17 want 0", bus.bcd_valid); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit stable;
    pulse(16'd30, 1'b1);
    repeat (15) @(negedge clk);
    pulse(16'hFFFF, 1'b1);
    stable = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.bcd !== 20'h00030) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin miscompares++; $display("FAIL bcd_stable: bcd moved during conversion, now %h want 00030", bus.bcd); end
    @(negedge clk);
    vectors++;
    if (bus.bcd_valid !== 1'b1 || bus.bcd !== 20'h65535) begin
      miscompares++;
      $display("FAIL b2b_second: valid=%b bcd=%h want 1 65535", bus.bcd_valid, bus.bcd);
    end
    vectors++;
    if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_boundary;
    int v0;
    v0 = valid_cnt;
    pulse(16'd0, 1'b1);
    repeat (18) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h00000) begin miscompares++; $display("FAIL zero_value: got %h want 00000", bus.bcd); end
    pulse(16'd9999, 1'b1);
    repeat (18) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h09999) begin miscompares++; $display("FAIL value_9999: got %h want 09999", bus.bcd); end
    vectors++;
    if (valid_cnt - v0 != 2) begin miscompares++; $display("FAIL boundary_pulses: got %0d valid pulses want 2", valid_cnt - v0); end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 65535));
      pulse(r, 1'b1);
      repeat (18) @(negedge clk);
    end
  endtask

  task automatic test_done_held;
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    bus.result = 16'd42;
    bus.done = 1'b1;
    exp_q.push_back(to_bcd(42));
    repeat (40) @(negedge clk);
    bus.done = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL held_pulses: got %0d want 1", valid_cnt - v0); end
    vectors++;
    if (bus.bcd !== 20'h00042) begin miscompares++; $display("FAIL held_bcd: got %h want 00042", bus.bcd); end
    vectors++;
    if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL held_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_overrun_e5;
    int v0;
    v0 = valid_cnt;
    pulse(16'd12, 1'b1);
    repeat (4) @(negedge clk);
    bus.result = 16'd500;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_e5_set: got %b want 1", bus.overrun); end
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h00012 || valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL overrun_e5_result: bcd=%h pulses=%0d want 00012 1", bus.bcd, valid_cnt - v0);
    end
    vectors++;
    if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear: got %b want 0", bus.overrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun_e16;
    int v0;
    v0 = valid_cnt;
    pulse(16'd12, 1'b1);
    repeat (14) @(negedge clk);
    @(negedge clk);
    bus.result = 16'd77;
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    vectors++;
    if (bus.overrun !== 1'b1 || bus.bcd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_e16: overrun=%b valid=%b want 1 1", bus.overrun, bus.bcd_valid);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h00012 || valid_cnt - v0 != 1) begin
      miscompares++;
      $display("FAIL overrun_e16_result: bcd=%h pulses=%0d want 00012 1", bus.bcd, valid_cnt - v0);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    v0 = valid_cnt;
    pulse(16'd999, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.bcd !== 20'h0 || bus.bcd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: bcd=%h valid=%b busy=%b overrun=%b want all 0",
               bus.bcd, bus.bcd_valid, bus.busy, bus.overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_cnt != v0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: pulses=%0d busy=%b want 0 0", valid_cnt - v0, bus.busy);
    end
    pulse(16'd321, 1'b1);
    repeat (20) @(negedge clk);
    vectors++;
    if (valid_cnt - v0 != 1 || bus.bcd !== 20'h00321) begin
      miscompares++;
      $display("FAIL convert_after_reset: pulses=%0d bcd=%h want 1 00321", valid_cnt - v0, bus.bcd);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_boundary();
    test_done_held();
    test_overrun_e5();
    test_overrun_e16();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL outstanding: %0d conversions never produced, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_bcd_conv.md
# result_bcd_conv

Sequential binary-to-BCD converter sitting directly downstream of the 8x8 multiplier. It captures the 16-bit product on each rising edge of the multiplier's `done` and converts it by shift-and-add-3 (double dabble) into five packed BCD digits for display and logging. The output register holds the last converted value and stays stable while the next conversion runs.

## Interface
- `WIDTH`, 16: binary input width; matches the multiplier `result`.
- `DIGITS`, 5: BCD digits produced; must equal ceil(WIDTH·log10 2).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `done` in 1: multiplier completion (level or pulse); only its rising edge is used.
- `result` in WIDTH: multiplier product; sampled on the capture edge only.
- `bcd` out 4·DIGITS: packed BCD, digit 0 (units) in bits [3:0].
- `bcd_valid` out 1: one-cycle pulse when `bcd` is updated.
- `busy` out 1: high while a conversion is in progress.
- `overrun` out 1: sticky; set when a `done` rising edge is dropped.

## Operation
- Edge detect: register `done_q` <= `done`. A rising edge is `done & ~done_q`.
- State machine with two states, IDLE and SHIFT.
  - IDLE, rising edge seen:
    - load `bin_sr` <= `result`, clear `bcd_sr` <= 0, `cnt` <= 0.
    - go to SHIFT; `busy` <= 1.
  - IDLE, no edge: hold.
  - SHIFT, each cycle:
    - every `bcd_sr` digit >= 5 gets +3 (4-bit add, no carry out of the digit).
    - then shift {`bcd_sr`, `bin_sr`} left by 1; `cnt` <= `cnt`+1.
  - SHIFT with `cnt` == WIDTH-1:
    - perform the final adjust and shift.
    - write the shifted `bcd_sr` value into `bcd`; `bcd_valid` <= 1.
    - `busy` <= 0; return to IDLE.
- `cnt` width: clog2(WIDTH). No digit ever exceeds 9 after a shift, and the top digit never overflows for DIGITS as specified.
- A rising edge of `done` while in SHIFT is ignored and sets `overrun` <= 1. The conversion in progress is unaffected.
- `done` held high for many cycles produces exactly one conversion.
- Reset value of every output and register is 0: `bcd`, `bcd_valid`, `busy`, `overrun`, `done_q`, `cnt`, shift registers; state IDLE.
  - Because `done_q` resets to 0, a `done` still high when `rst_n` releases counts as a rising edge and converts.
- Reset mid-conversion aborts at once. No `bcd_valid` is produced and `bcd` reads 0.

## Timing
- Capture at edge E0 (first edge with `done`=1 and `done_q`=0, in IDLE). `busy` is high from E0.
- Shift edges E1..E16. At E16: `bcd` is updated, `bcd_valid`=1, `busy`=0.
- `bcd_valid` falls at E17. Latency is WIDTH cycles from capture edge to valid.
- Earliest next capture: E17, if a new rising edge is present at E17.
  - A rising edge sampled exactly at E16 is still in SHIFT, so it is dropped and `overrun` is set.
- `bcd` changes only at completion edges and at reset.

## Structure
- Package `bcd_conv_pkg` contains:
  - state enum {ST_IDLE, ST_SHIFT}
  - default constants BCD_WIDTH=16, BCD_DIGITS=5
  - function `clog2`
- Sub-module `bcd_digit_adj`: purely combinational, 4-bit in/out, applies +3 when the input is >= 5. Instantiated DIGITS times by generate.
- The top holds the FSM, edge detect, counter, shift registers and output registers.

## Test plan
- `result`=12, `done` pulsed → after 16 cycles, `bcd`=20'h00012 and `bcd_valid` high for exactly 1 cycle.
- `result`=30, then `result`=65535 in back-to-back conversions → `bcd`=20'h00030, then 20'h65535; `bcd` stable between the two completions.
- `result`=0 → `bcd`=20'h00000 with a `bcd_valid` pulse. Boundary value 9999 → 20'h09999.
- `done` held high 40 cycles with `result`=42 → exactly one `bcd_valid` and `bcd`=20'h00042; `overrun` stays 0.
- Second `done` rise at E5 of a conversion of 12 → result still 20'h00012, `overrun`=1 and remains 1 until reset. Repeat with the second rise at E16 → also dropped, `overrun`=1.
- `rst_n` low at E8 of a conversion of 999 → all outputs 0 on the next edge, no `bcd_valid`. After release with `done` low, the block stays idle; the next `done` rise converts normally.
